// File: rtl/ise_pkg.sv
// Shared definitions for the image sorting engine output scheduler.
// Optional feature macro: ISE_SCHED_INDEX_TIEBREAK_EN (appends the image
// index to the sort key so equal colour/mean records order by index).
package ise_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } sched_state_t;

  localparam logic [1:0] COLOR_R     = 2'd0;
  localparam logic [1:0] COLOR_G     = 2'd1;
  localparam logic [1:0] COLOR_B     = 2'd2;
  localparam logic [1:0] COLOR_UNDET = 2'd3;

  localparam int ISE_MAX_IMG = 32;
  localparam int ISE_IDX_W   = 5;
  localparam int ISE_MEAN_W  = 8;

  // Sort key is {colour, mean} and optionally the image index below them.
  function automatic int key_width(input int idx_w, input int mean_w);
`ifdef ISE_SCHED_INDEX_TIEBREAK_EN
    return 2 + mean_w + idx_w;
`else
    return 2 + mean_w;
`endif
  endfunction

endpackage

// File: rtl/ise_sort_cell.sv
// One slot of the insertion-sort chain. A slot is "big" when it is empty or
// holds a key strictly greater than the incoming one; because the list is
// kept sorted, big slots always form a contiguous run at the top.
module ise_sort_cell
  import ise_pkg::*;
#(
  parameter int KEY_W = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ins_en,
  input  logic             occupied,
  input  logic             lower_big,
  input  logic [KEY_W-1:0] lower_key,
  input  logic [IDX_W-1:0] lower_idx,
  input  logic [KEY_W-1:0] new_key,
  input  logic [IDX_W-1:0] new_idx,
  output logic             big,
  output logic [KEY_W-1:0] key,
  output logic [IDX_W-1:0] idx
);

  logic [KEY_W-1:0] key_reg;
  logic [IDX_W-1:0] idx_reg;

  // Strict compare keeps equal keys in arrival order.
  assign big = !occupied || (key_reg > new_key);
  assign key = key_reg;
  assign idx = idx_reg;

  // Shift up from the lower neighbour, take the new record, or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_reg <= '0;
      idx_reg <= '0;
    end else if (ins_en) begin
      if (lower_big) begin
        key_reg <= lower_key;
        idx_reg <= lower_idx;
      end else if (big) begin
        key_reg <= new_key;
        idx_reg <= new_idx;
      end
    end
  end

endmodule

// File: rtl/ise_order_sched.sv
// Output-ordering scheduler: inserts per-image records into a sorted chain
// as they arrive, then streams image indices out in ascending key order.
// Optional feature macro: ISE_SCHED_INDEX_TIEBREAK_EN.
module ise_order_sched
  import ise_pkg::*;
#(
  parameter int MAX_IMG = ISE_MAX_IMG,
  parameter int IDX_W   = ISE_IDX_W,
  parameter int MEAN_W  = ISE_MEAN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [IDX_W-1:0]  rec_index,
  input  logic [1:0]        rec_color,
  input  logic [MEAN_W-1:0] rec_mean,
  input  logic              rec_last,
  output logic              busy,
  output logic              out_valid,
  output logic [1:0]        color_index,
  output logic [IDX_W-1:0]  image_out_index
);

  localparam int KEY_W = key_width(IDX_W, MEAN_W);
  localparam int CNT_W = $clog2(MAX_IMG + 1);
  localparam int PTR_W = $clog2(MAX_IMG);

  sched_state_t     state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] ptr_reg;
  logic             accept;
  logic             last_out;
  logic [KEY_W-1:0] new_key;
  logic [KEY_W-1:0] sel_key;
  logic [IDX_W-1:0] sel_idx;

  logic             big_arr [MAX_IMG];
  logic [KEY_W-1:0] key_arr [MAX_IMG];
  logic [IDX_W-1:0] idx_arr [MAX_IMG];

`ifdef ISE_SCHED_INDEX_TIEBREAK_EN
  assign new_key = {rec_color, rec_mean, rec_index};
`else
  assign new_key = {rec_color, rec_mean};
`endif

  assign accept   = rec_valid && rec_ready;
  assign last_out = (ptr_reg == count_reg - CNT_W'(1));

  genvar gi;
  generate
    for (gi = 0; gi < MAX_IMG; gi++) begin : g_cell
      logic             lower_big;
      logic [KEY_W-1:0] lower_key;
      logic [IDX_W-1:0] lower_idx;
      if (gi == 0) begin : g_bottom
        assign lower_big = 1'b0;
        assign lower_key = '0;
        assign lower_idx = '0;
      end else begin : g_chain
        assign lower_big = big_arr[gi-1];
        assign lower_key = key_arr[gi-1];
        assign lower_idx = idx_arr[gi-1];
      end
      ise_sort_cell #(.KEY_W(KEY_W), .IDX_W(IDX_W)) u_cell (
        .clk       (clk),
        .reset     (reset),
        .ins_en    (accept),
        .occupied  (CNT_W'(gi) < count_reg),
        .lower_big (lower_big),
        .lower_key (lower_key),
        .lower_idx (lower_idx),
        .new_key   (new_key),
        .new_idx   (rec_index),
        .big       (big_arr[gi]),
        .key       (key_arr[gi]),
        .idx       (idx_arr[gi])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next state and handshake outputs; the batch closes on rec_last or a full list.
  always_comb begin
    state_next = state_reg;
    rec_ready  = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_COLLECT: begin
        rec_ready = 1'b1;
        if (rec_valid) begin
          if (rec_last || count_reg == CNT_W'(MAX_IMG - 1)) state_next = ST_EMIT;
          else                                              state_next = ST_COLLECT;
        end
      end
      ST_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (last_out) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Entry count grows per accept and clears when emission finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              count_reg <= '0;
    else if (accept)                         count_reg <= count_reg + CNT_W'(1);
    else if (state_reg == ST_EMIT && last_out) count_reg <= '0;
  end

  // Read pointer walks 0..count-1 during emission only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  ptr_reg <= '0;
    else if (state_reg == ST_EMIT && !last_out)  ptr_reg <= ptr_reg + CNT_W'(1);
    else                                         ptr_reg <= '0;
  end

  assign sel_key = key_arr[ptr_reg[PTR_W-1:0]];
  assign sel_idx = idx_arr[ptr_reg[PTR_W-1:0]];

  assign color_index     = out_valid ? sel_key[KEY_W-1 -: 2] : 2'd0;
  assign image_out_index = out_valid ? sel_idx : '0;

endmodule

// File: tb/tb_ise_order_sched.sv
// Directed bench for ise_order_sched; expectations are hand-derived sort orders.
module tb_ise_order_sched;
  localparam int IDX_W  = 5;
  localparam int MEAN_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rec_valid = 1'b0;
  logic              rec_ready;
  logic [IDX_W-1:0]  rec_index = '0;
  logic [1:0]        rec_color = '0;
  logic [MEAN_W-1:0] rec_mean = '0;
  logic              rec_last = 1'b0;
  logic              busy;
  logic              out_valid;
  logic [1:0]        color_index;
  logic [IDX_W-1:0]  image_out_index;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_idx [32];
  int exp_col [32];

  ise_order_sched #(.MAX_IMG(32), .IDX_W(IDX_W), .MEAN_W(MEAN_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_index       (rec_index),
    .rec_color       (rec_color),
    .rec_mean        (rec_mean),
    .rec_last        (rec_last),
    .busy            (busy),
    .out_valid       (out_valid),
    .color_index     (color_index),
    .image_out_index (image_out_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Present one record at a negedge; it is accepted at the following posedge.
  task automatic send(input int idx, input int col, input int mean, input bit last);
    rec_valid = 1'b1;
    rec_index = IDX_W'(idx);
    rec_color = 2'(col);
    rec_mean  = MEAN_W'(mean);
    rec_last  = last;
    @(negedge clk);
    rec_valid = 1'b0;
    rec_last  = 1'b0;
  endtask

  // Check n consecutive outputs against exp_idx/exp_col, then the idle state.
  task automatic emit_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.valid[%0d]", tag, k), int'(out_valid), 1);
      chk($sformatf("%s.idx[%0d]", tag, k), int'(image_out_index), exp_idx[k]);
      chk($sformatf("%s.col[%0d]", tag, k), int'(color_index), exp_col[k]);
      @(negedge clk);
    end
    chk({tag, ".busy_end"}, int'(busy), 0);
    chk({tag, ".valid_end"}, int'(out_valid), 0);
    chk({tag, ".ready_end"}, int'(rec_ready), 1);
    chk({tag, ".idx_end"}, int'(image_out_index), 0);
    $display("%s: %0d outputs checked", tag, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.ready", int'(rec_ready), 1);
    chk("rst.col", int'(color_index), 0);
    chk("rst.idx", int'(image_out_index), 0);
    $display("reset state checked");

    // Mixed colours: R20(9) R200(7) G5(1) B10(3).
    send(3, 2, 10, 1'b0);
    chk("mix.ready_collect", int'(rec_ready), 1);
    chk("mix.busy_collect", int'(busy), 0);
    send(7, 0, 200, 1'b0);
    send(1, 1, 5, 1'b0);
    send(9, 0, 20, 1'b1);
    exp_idx[0] = 9; exp_col[0] = 0;
    exp_idx[1] = 7; exp_col[1] = 0;
    exp_idx[2] = 1; exp_col[2] = 1;
    exp_idx[3] = 3; exp_col[3] = 2;
    chk("mix.busy", int'(busy), 1);
    chk("mix.ready", int'(rec_ready), 0);
    emit_check("mix", 4);

    // Equal keys.
    send(4, 1, 50, 1'b0);
    send(2, 1, 50, 1'b1);
`ifdef ISE_SCHED_INDEX_TIEBREAK_EN
    exp_idx[0] = 2; exp_idx[1] = 4;
`else
    exp_idx[0] = 4; exp_idx[1] = 2;
`endif
    exp_col[0] = 1; exp_col[1] = 1;
    emit_check("tie", 2);

    // Undetermined colour sorts after blue.
    send(5, 3, 0, 1'b0);
    send(6, 2, 255, 1'b1);
    exp_idx[0] = 6; exp_col[0] = 2;
    exp_idx[1] = 5; exp_col[1] = 3;
    emit_check("undet", 2);

    // Full list without rec_last: mean = 31-i, so index 31 emerges first.
    for (int i = 0; i < 32; i++) begin
      send(i, 1, 31 - i, 1'b0);
      if (i == 30) chk("full.ready_31", int'(rec_ready), 1);
    end
    chk("full.ready_drop", int'(rec_ready), 0);
    chk("full.busy", int'(busy), 1);
    for (int k = 0; k < 32; k++) begin
      exp_idx[k] = 31 - k;
      exp_col[k] = 1;
    end
    emit_check("full", 32);

    // rec_valid held during emission must not add entries.
    send(10, 0, 1, 1'b0);
    send(11, 0, 2, 1'b1);
    rec_valid = 1'b1;
    rec_index = IDX_W'(20);
    rec_color = 2'd3;
    rec_mean  = '0;
    rec_last  = 1'b1;
    exp_idx[0] = 10; exp_col[0] = 0;
    exp_idx[1] = 11; exp_col[1] = 0;
    emit_check("hold", 2);
    rec_valid = 1'b0;
    rec_last  = 1'b0;
    send(21, 1, 7, 1'b1);
    exp_idx[0] = 21; exp_col[0] = 1;
    emit_check("after_hold", 1);

    // Reset in the middle of a 5-record emission.
    for (int i = 0; i < 5; i++) send(i, 0, 10 * i, i == 4);
    chk("abort.idx0", int'(image_out_index), 0);
    chk("abort.valid0", int'(out_valid), 1);
    @(negedge clk);
    chk("abort.idx1", int'(image_out_index), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort.busy", int'(busy), 0);
    chk("abort.valid", int'(out_valid), 0);
    chk("abort.col", int'(color_index), 0);
    chk("abort.idx", int'(image_out_index), 0);
    chk("abort.ready", int'(rec_ready), 1);
    reset = 1'b1;
    @(negedge clk);
    send(12, 2, 3, 1'b1);
    exp_idx[0] = 12; exp_col[0] = 2;
    emit_check("post_abort", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ise_order_sched.md
# ise_order_sched

Output-ordering scheduler for the image sorting engine. It collects one summary record per image from the colour-statistics datapath: image index, dominant colour class and mean intensity. Each record is inserted into a sorted list as it arrives. After the last record, the block streams the image indices out in sorted order, one per cycle, using the engine's `busy` / `out_valid` / `color_index` / `image_out_index` convention.

## Interface
- `MAX_IMG`, 32: maximum records per batch.
- `IDX_W`, 5: image index width; must be at least log2(`MAX_IMG`).
- `MEAN_W`, 8: mean-intensity width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rec_valid` input 1: record offered this cycle.
- `rec_ready` output 1: record can be accepted; transfer occurs when `rec_valid && rec_ready`.
- `rec_index` input `IDX_W`: image index of the record.
- `rec_color` input 2: colour class; 0 = R, 1 = G, 2 = B, 3 = undetermined.
- `rec_mean` input `MEAN_W`: mean intensity of the dominant channel.
- `rec_last` input 1: marks the final record of the batch.
- `busy` output 1: emission in progress; no records accepted.
- `out_valid` output 1: `color_index` and `image_out_index` are valid.
- `color_index` output 2: colour class of the emitted image.
- `image_out_index` output `IDX_W`: emitted image index.

## Operation
- **States:**
  - IDLE: `count` = 0, `rec_ready` = 1.
  - COLLECT: `rec_ready` = 1.
  - EMIT: `busy` = 1, `rec_ready` = 0.
- **Transitions:**
  - IDLE → COLLECT on the first accepted record without `rec_last`.
  - IDLE or COLLECT → EMIT on an accepted record with `rec_last`.
  - IDLE or COLLECT → EMIT on the accept that makes `count` == `MAX_IMG`, whether or not `rec_last` is set.
  - EMIT → IDLE after the entry at position `count`−1 is emitted.
- **Sort key:** {`rec_color`, `rec_mean`}, compared as an unsigned 10-bit value (2-bit colour above the mean), ascending. R comes before G before B before undetermined. Lower mean comes first within a colour.
- **Insertion (one accept per cycle, no stall):**
  - Every stored entry compares its key with the incoming key in parallel.
  - Entries with key greater than the incoming key shift up one slot.
  - The new record lands in the vacated slot.
  - `count` increments.
- **Ties:** equal keys keep arrival order (stable) unless the macro in Configuration is defined.
- **Emission:** read pointer runs 0..`count`−1, one entry per cycle. `out_valid` = 1 on each of those cycles. `color_index` and `image_out_index` come from the slot at the pointer.
- **Outputs when `out_valid` = 0:** `color_index` and `image_out_index` are driven to 0.
- **Duplicate `rec_index`:** not checked; both entries are emitted.
- **`rec_valid` during EMIT:** ignored, because `rec_ready` = 0.
- **Reset (any state, including mid-EMIT):** aborts the batch.
  - `count` = 0, pointer = 0, state = IDLE.
  - `busy` = 0, `out_valid` = 0, `color_index` = 0, `image_out_index` = 0.
  - `rec_ready` = 1 immediately after reset.

## Timing
- Accepting a record with `rec_last` at edge t:
  - `busy` = 1 and first `out_valid` from t+1.
  - Last `out_valid` at t+`count`.
  - `busy` = 0, `out_valid` = 0, `rec_ready` = 1 at t+`count`+1.
- Back-to-back batches: a new record can be accepted on the cycle `rec_ready` returns to 1.
- Single-record batch (`rec_last` on the first record): exactly one `out_valid` cycle, at t+1.
- Full list: the `MAX_IMG`th accept forces EMIT at the next cycle. The entry count is preserved, so `MAX_IMG` outputs follow.
- Comparator and shift path is single-cycle combinational. It is registered into the storage slots at the accept edge.

## Configuration
- `ISE_SCHED_INDEX_TIEBREAK_EN`:
  - Defined: the key is extended with `rec_index` as the least significant field, so equal colour and mean order by ascending image index.
  - Undefined: equal keys emit in arrival order.

## Structure
- Shared package `ise_pkg` holds:
  - State enum (IDLE, COLLECT, EMIT).
  - Colour-class constants (R = 0, G = 1, B = 2, UNDET = 3).
  - `MAX_IMG`, `IDX_W`, `MEAN_W` defaults.
  - Key-width function (10 bits, or 10+`IDX_W` with tiebreak enabled).
- Sub-module `ise_sort_cell`, instantiated `MAX_IMG` times as a chain. Each cell holds one entry and does the following:
  - Compares its key with the incoming key.
  - Chooses between hold, load-new and load-from-lower-neighbour.
  - Reports "my key > new" to the cell above.
- The top holds the FSM, `count`, the read pointer and the output mux.

## Test plan
- Reset with `reset` = 0 mid-EMIT of a 5-record batch → next cycle `busy` = 0, `out_valid` = 0, outputs 0, `rec_ready` = 1; a fresh 1-record batch then emits correctly.
- Records (idx, colour, mean) arriving in order: (3,B,10), (7,R,200), (1,G,5), (9,R,20) with last on idx 9 → output order 9, 7, 1, 3 with `color_index` 0, 0, 1, 2, on 4 consecutive cycles starting 1 cycle after the last accept.
- Ties (4,G,50), (2,G,50) → order 4, 2 without the macro; 2, 4 with `ISE_SCHED_INDEX_TIEBREAK_EN`.
- 32 records without `rec_last`, mean = 31−i → `rec_ready` drops after the 32nd accept and 32 outputs emit with mean ascending.
- `rec_valid` held high during EMIT → no acceptance, `count` unchanged; the next batch starts at `rec_ready` = 1.
- Colour 3 record (5,UNDET,0) mixed with (6,B,255) → 6 emitted before 5.
